// File: rtl/game_constants_pkg.sv
// Shared constants and types for the pong match-flow logic.
package game_constants_pkg;

  // Match sequencer states; encoding is visible on the match_state output.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    PAUSED = 3'd3,
    POINT  = 3'd4,
    OVER   = 3'd5
  } match_state_t;

  // Default timing at the 10 kHz game clock, and match length.
  localparam int unsigned SERVE_DELAY_IN_CLOCKS = 10000;
  localparam int unsigned POINT_PAUSE_IN_CLOCKS = 20000;
  localparam int unsigned WINNING_SCORE         = 7;

  // Serve direction: toward player 1 (left) or player 2 (right).
  localparam logic SERVE_DIR_LEFT  = 1'b0;
  localparam logic SERVE_DIR_RIGHT = 1'b1;

  // Winner encoding.
  localparam logic WINNER_PLAYER_1 = 1'b0;
  localparam logic WINNER_PLAYER_2 = 1'b1;

endpackage

// File: rtl/match_timer.sv
// Loadable down-counter shared by the SERVE and POINT dwell phases.
module match_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] count_q, count_d;

  // Load wins over counting; the counter parks at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/pong_match_sequencer.sv
// Match-flow controller: gates ball motion, requests ball re-init, picks the
// serve direction and keeps score. All outputs come straight from flops.
module pong_match_sequencer #(
  parameter int unsigned SERVE_DELAY_IN_CLOCKS = game_constants_pkg::SERVE_DELAY_IN_CLOCKS,
  parameter int unsigned POINT_PAUSE_IN_CLOCKS = game_constants_pkg::POINT_PAUSE_IN_CLOCKS,
  parameter int unsigned WINNING_SCORE         = game_constants_pkg::WINNING_SCORE,
  parameter int unsigned SCORE_WIDTH           = $clog2(WINNING_SCORE + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_req,
  input  logic                   pause_req,
  input  logic                   miss_left,
  input  logic                   miss_right,
  output logic                   play_en,
  output logic                   ball_reinit,
  output logic                   serve_dir,
  output logic [SCORE_WIDTH-1:0] score_1,
  output logic [SCORE_WIDTH-1:0] score_2,
  output logic                   game_over,
  output logic                   winner,
  output logic [2:0]             match_state
);

  import game_constants_pkg::*;

  localparam int unsigned MAX_DELAY = (SERVE_DELAY_IN_CLOCKS > POINT_PAUSE_IN_CLOCKS) ?
                                      SERVE_DELAY_IN_CLOCKS : POINT_PAUSE_IN_CLOCKS;
  localparam int unsigned TIMER_WIDTH = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  // Timer counts down to zero inclusive, so load delay-1.
  localparam logic [TIMER_WIDTH-1:0] SERVE_LOAD = TIMER_WIDTH'(SERVE_DELAY_IN_CLOCKS - 1);
  localparam logic [TIMER_WIDTH-1:0] POINT_LOAD = TIMER_WIDTH'(POINT_PAUSE_IN_CLOCKS - 1);
  localparam logic [SCORE_WIDTH-1:0] WIN        = SCORE_WIDTH'(WINNING_SCORE);

  match_state_t state_q, state_d;

  logic                   play_en_q, play_en_d;
  logic                   ball_reinit_q, ball_reinit_d;
  logic                   serve_dir_q, serve_dir_d;
  logic [SCORE_WIDTH-1:0] score_1_q, score_1_d;
  logic [SCORE_WIDTH-1:0] score_2_q, score_2_d;
  logic                   game_over_q, game_over_d;
  logic                   winner_q, winner_d;

  logic                   timer_load;
  logic [TIMER_WIDTH-1:0] timer_load_value;
  logic                   timer_en;
  logic                   timer_expired;

  logic                   miss_left_only, miss_right_only, miss_both;
  logic [SCORE_WIDTH-1:0] score_1_inc, score_2_inc;

  assign miss_left_only  = miss_left & ~miss_right;
  assign miss_right_only = miss_right & ~miss_left;
  assign miss_both       = miss_left & miss_right;

  // Saturating increments so a score can never wrap past the winning value.
  assign score_1_inc = (score_1_q < WIN) ? score_1_q + SCORE_WIDTH'(1) : score_1_q;
  assign score_2_inc = (score_2_q < WIN) ? score_2_q + SCORE_WIDTH'(1) : score_2_q;

  assign timer_en = (state_q == SERVE) || (state_q == POINT);

  match_timer #(
    .WIDTH (TIMER_WIDTH)
  ) u_match_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_load_value),
    .en         (timer_en),
    .expired    (timer_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; misses take priority over pause in PLAY.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, OVER: begin
        if (start_req) state_d = SERVE;
      end
      SERVE: begin
        if (timer_expired) state_d = PLAY;
      end
      PLAY: begin
        if (miss_left_only) begin
          state_d = (score_2_inc == WIN) ? OVER : POINT;
        end else if (miss_right_only) begin
          state_d = (score_1_inc == WIN) ? OVER : POINT;
        end else if (miss_both) begin
          state_d = POINT;
        end else if (pause_req) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (pause_req) state_d = PLAY;
      end
      POINT: begin
        if (timer_expired) state_d = SERVE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs and the timer controls.
  always_comb begin
    ball_reinit_d    = 1'b0;
    serve_dir_d      = serve_dir_q;
    score_1_d        = score_1_q;
    score_2_d        = score_2_q;
    winner_d         = winner_q;
    timer_load       = 1'b0;
    timer_load_value = SERVE_LOAD;
    unique case (state_q)
      IDLE, OVER: begin
        if (start_req) begin
          score_1_d     = '0;
          score_2_d     = '0;
          winner_d      = WINNER_PLAYER_1;
          ball_reinit_d = 1'b1;
          timer_load    = 1'b1;
        end
      end
      PLAY: begin
        if (miss_left_only) begin
          score_2_d   = score_2_inc;
          serve_dir_d = SERVE_DIR_LEFT;
          if (score_2_inc == WIN) begin
            winner_d = WINNER_PLAYER_2;
          end else begin
            timer_load       = 1'b1;
            timer_load_value = POINT_LOAD;
          end
        end else if (miss_right_only) begin
          score_1_d   = score_1_inc;
          serve_dir_d = SERVE_DIR_RIGHT;
          if (score_1_inc == WIN) begin
            winner_d = WINNER_PLAYER_1;
          end else begin
            timer_load       = 1'b1;
            timer_load_value = POINT_LOAD;
          end
        end else if (miss_both) begin
          timer_load       = 1'b1;
          timer_load_value = POINT_LOAD;
        end
      end
      POINT: begin
        if (timer_expired) begin
          ball_reinit_d = 1'b1;
          timer_load    = 1'b1;
        end
      end
      default: ;
    endcase
    play_en_d   = (state_d == PLAY);
    game_over_d = (state_d == OVER);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      play_en_q     <= 1'b0;
      ball_reinit_q <= 1'b0;
      serve_dir_q   <= SERVE_DIR_LEFT;
      score_1_q     <= '0;
      score_2_q     <= '0;
      game_over_q   <= 1'b0;
      winner_q      <= WINNER_PLAYER_1;
    end else begin
      play_en_q     <= play_en_d;
      ball_reinit_q <= ball_reinit_d;
      serve_dir_q   <= serve_dir_d;
      score_1_q     <= score_1_d;
      score_2_q     <= score_2_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
    end
  end

  assign play_en     = play_en_q;
  assign ball_reinit = ball_reinit_q;
  assign serve_dir   = serve_dir_q;
  assign score_1     = score_1_q;
  assign score_2     = score_2_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;
  assign match_state = state_q;

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Self-checking bench for pong_match_sequencer with short delays.
module tb_pong_match_sequencer;
  import game_constants_pkg::*;

  localparam int unsigned SD = 4;
  localparam int unsigned PP = 3;
  localparam int unsigned WS = 2;
  localparam int unsigned SW = $clog2(WS + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_req = 1'b0;
  logic          pause_req = 1'b0;
  logic          miss_left = 1'b0;
  logic          miss_right = 1'b0;
  logic          play_en;
  logic          ball_reinit;
  logic          serve_dir;
  logic [SW-1:0] score_1;
  logic [SW-1:0] score_2;
  logic          game_over;
  logic          winner;
  logic [2:0]    match_state;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0]    st;
    logic          pe;
    logic          rb;
    logic          dir;
    logic [SW-1:0] s1;
    logic [SW-1:0] s2;
    logic          ov;
    logic          win;
  } obs_t;

  typedef struct packed {
    logic start;
    logic pause;
    logic ml;
    logic mr;
    obs_t exp;
  } step_t;

  // Scoreboard: stimulus for one cycle plus the outputs required after that edge.
  step_t sb[$];

  pong_match_sequencer #(
    .SERVE_DELAY_IN_CLOCKS (SD),
    .POINT_PAUSE_IN_CLOCKS (PP),
    .WINNING_SCORE         (WS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_req   (start_req),
    .pause_req   (pause_req),
    .miss_left   (miss_left),
    .miss_right  (miss_right),
    .play_en     (play_en),
    .ball_reinit (ball_reinit),
    .serve_dir   (serve_dir),
    .score_1     (score_1),
    .score_2     (score_2),
    .game_over   (game_over),
    .winner      (winner),
    .match_state (match_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  function automatic obs_t get_obs();
    obs_t o;
    o.st  = match_state;
    o.pe  = play_en;
    o.rb  = ball_reinit;
    o.dir = serve_dir;
    o.s1  = score_1;
    o.s2  = score_2;
    o.ov  = game_over;
    o.win = winner;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d pe=%b rb=%b dir=%b s1=%0d s2=%0d ov=%b win=%b",
                     o.st, o.pe, o.rb, o.dir, o.s1, o.s2, o.ov, o.win);
  endfunction

  function automatic void push(input logic st_r, input logic pa, input logic ml,
                               input logic mr, input match_state_t st, input logic pe,
                               input logic rb, input logic dir, input int s1, input int s2,
                               input logic ov, input logic win);
    step_t s;
    s.start   = st_r;
    s.pause   = pa;
    s.ml      = ml;
    s.mr      = mr;
    s.exp.st  = st;
    s.exp.pe  = pe;
    s.exp.rb  = rb;
    s.exp.dir = dir;
    s.exp.s1  = SW'(s1);
    s.exp.s2  = SW'(s2);
    s.exp.ov  = ov;
    s.exp.win = win;
    sb.push_back(s);
  endfunction

  // After the re-init cycle: remaining SD-1 serve cycles, then play.
  function automatic void push_serve_tail(input logic dir, input int s1, input int s2);
    for (int i = 0; i < int'(SD) - 1; i++) push(0, 0, 0, 0, SERVE, 0, 0, dir, s1, s2, 0, 0);
    push(0, 0, 0, 0, PLAY, 1, 0, dir, s1, s2, 0, 0);
  endfunction

  // After the first POINT cycle: remaining POINT cycles, re-init, serve, play.
  function automatic void push_point_tail(input logic dir, input int s1, input int s2);
    for (int i = 0; i < int'(PP) - 1; i++) push(0, 0, 0, 0, POINT, 0, 0, dir, s1, s2, 0, 0);
    push(0, 0, 0, 0, SERVE, 0, 1, dir, s1, s2, 0, 0);
    push_serve_tail(dir, s1, s2);
  endfunction

  // Apply one scoreboard entry's stimulus across a rising edge; sample on the falling edge.
  task automatic tick(input step_t s);
    start_req  = s.start;
    pause_req  = s.pause;
    miss_left  = s.ml;
    miss_right = s.mr;
    @(posedge clk);
    @(negedge clk);
    start_req  = 1'b0;
    pause_req  = 1'b0;
    miss_left  = 1'b0;
    miss_right = 1'b0;
  endtask

  task automatic test_reset();
    step_t s;
    obs_t  o;
    int    n = 0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    o = get_obs();
    checks++;
    if (o !== obs_t'(0)) begin
      errors++;
      $display("FAIL test_reset in-reset: got %s need %s", fmt(o), fmt(obs_t'(0)));
    end
    rst = 1'b1;
    push(0, 0, 1, 0, IDLE, 0, 0, 0, 0, 0, 0, 0);
    push(0, 1, 0, 1, IDLE, 0, 0, 0, 0, 0, 0, 0);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      tick(s);
      o = get_obs();
      checks++;
      if (o !== s.exp) begin
        errors++;
        $display("FAIL test_reset[%0d]: got %s need %s", n, fmt(o), fmt(s.exp));
      end
      n++;
    end
  endtask

  task automatic test_start();
    step_t s;
    obs_t  o;
    int    n = 0;
    push(1, 0, 0, 0, SERVE, 0, 1, 0, 0, 0, 0, 0);
    push_serve_tail(0, 0, 0);
    push(0, 0, 0, 0, PLAY, 1, 0, 0, 0, 0, 0, 0);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      tick(s);
      o = get_obs();
      checks++;
      if (o !== s.exp) begin
        errors++;
        $display("FAIL test_start[%0d]: got %s need %s", n, fmt(o), fmt(s.exp));
      end
      n++;
    end
  endtask

  task automatic test_point();
    step_t s;
    obs_t  o;
    int    n = 0;
    push(0, 0, 0, 1, POINT, 0, 0, 1, 1, 0, 0, 0);
    push_point_tail(1, 1, 0);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      tick(s);
      o = get_obs();
      checks++;
      if (o !== s.exp) begin
        errors++;
        $display("FAIL test_point[%0d]: got %s need %s", n, fmt(o), fmt(s.exp));
      end
      n++;
    end
  endtask

  task automatic test_double_miss();
    step_t s;
    obs_t  o;
    int    n = 0;
    push(0, 0, 1, 1, POINT, 0, 0, 1, 1, 0, 0, 0);
    push_point_tail(1, 1, 0);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      tick(s);
      o = get_obs();
      checks++;
      if (o !== s.exp) begin
        errors++;
        $display("FAIL test_double_miss[%0d]: got %s need %s", n, fmt(o), fmt(s.exp));
      end
      n++;
    end
  endtask

  task automatic test_pause();
    step_t s;
    obs_t  o;
    int    n = 0;
    push(0, 1, 0, 0, PAUSED, 0, 0, 1, 1, 0, 0, 0);
    push(0, 0, 1, 0, PAUSED, 0, 0, 1, 1, 0, 0, 0);
    push(0, 0, 0, 1, PAUSED, 0, 0, 1, 1, 0, 0, 0);
    push(1, 0, 0, 0, PAUSED, 0, 0, 1, 1, 0, 0, 0);
    push(0, 1, 0, 0, PLAY, 1, 0, 1, 1, 0, 0, 0);
    push(1, 0, 0, 0, PLAY, 1, 0, 1, 1, 0, 0, 0);
    // Miss beats a simultaneous pause.
    push(0, 1, 1, 0, POINT, 0, 0, 0, 1, 1, 0, 0);
    push_point_tail(0, 1, 1);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      tick(s);
      o = get_obs();
      checks++;
      if (o !== s.exp) begin
        errors++;
        $display("FAIL test_pause[%0d]: got %s need %s", n, fmt(o), fmt(s.exp));
      end
      n++;
    end
  endtask

  task automatic test_win();
    step_t s;
    obs_t  o;
    int    n = 0;
    push(0, 0, 1, 0, OVER, 0, 0, 0, 1, 2, 1, 1);
    push(0, 0, 1, 0, OVER, 0, 0, 0, 1, 2, 1, 1);
    push(0, 1, 0, 1, OVER, 0, 0, 0, 1, 2, 1, 1);
    push(1, 0, 0, 0, SERVE, 0, 1, 0, 0, 0, 0, 0);
    push_serve_tail(0, 0, 0);
    push(0, 0, 1, 0, POINT, 0, 0, 0, 0, 1, 0, 0);
    push_point_tail(0, 0, 1);
    push(0, 0, 1, 0, OVER, 0, 0, 0, 0, 2, 1, 1);
    push(0, 0, 0, 0, OVER, 0, 0, 0, 0, 2, 1, 1);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      tick(s);
      o = get_obs();
      checks++;
      if (o !== s.exp) begin
        errors++;
        $display("FAIL test_win[%0d]: got %s need %s", n, fmt(o), fmt(s.exp));
      end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    step_t s;
    obs_t  o;
    int    n = 0;
    push(1, 0, 0, 0, SERVE, 0, 1, 0, 0, 0, 0, 0);
    push_serve_tail(0, 0, 0);
    push(0, 0, 0, 1, POINT, 0, 0, 1, 1, 0, 0, 0);
    push_point_tail(1, 1, 0);
    push(0, 0, 0, 1, OVER, 0, 0, 1, 2, 0, 1, 0);
    push(0, 0, 0, 1, OVER, 0, 0, 1, 2, 0, 1, 0);
    push(1, 0, 0, 0, SERVE, 0, 1, 1, 0, 0, 0, 0);
    push_serve_tail(1, 0, 0);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      tick(s);
      o = get_obs();
      checks++;
      if (o !== s.exp) begin
        errors++;
        $display("FAIL test_back_to_back[%0d]: got %s need %s", n, fmt(o), fmt(s.exp));
      end
      n++;
    end
  endtask

  task automatic test_async_reset();
    step_t s;
    obs_t  o;
    int    n = 0;
    push(0, 0, 1, 0, POINT, 0, 0, 0, 0, 1, 0, 0);
    push(0, 0, 0, 0, POINT, 0, 0, 0, 0, 1, 0, 0);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      tick(s);
      o = get_obs();
      checks++;
      if (o !== s.exp) begin
        errors++;
        $display("FAIL test_async_reset pre[%0d]: got %s need %s", n, fmt(o), fmt(s.exp));
      end
      n++;
    end
    // Drop reset between edges; outputs must clear before the next rising edge.
    #2;
    rst = 1'b0;
    #1;
    o = get_obs();
    checks++;
    if (o !== obs_t'(0)) begin
      errors++;
      $display("FAIL test_async_reset mid-cycle: got %s need %s", fmt(o), fmt(obs_t'(0)));
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    push(0, 0, 1, 0, IDLE, 0, 0, 0, 0, 0, 0, 0);
    push(0, 1, 0, 0, IDLE, 0, 0, 0, 0, 0, 0, 0);
    push(1, 0, 0, 0, SERVE, 0, 1, 0, 0, 0, 0, 0);
    push_serve_tail(0, 0, 0);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      tick(s);
      o = get_obs();
      checks++;
      if (o !== s.exp) begin
        errors++;
        $display("FAIL test_async_reset post[%0d]: got %s need %s", n, fmt(o), fmt(s.exp));
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_point();
    test_double_miss();
    test_pause();
    test_win();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pong_match_sequencer.md
Name: pong_match_sequencer

Overview:
Match-flow controller for the pong game. It runs in the slow game clock domain beside game_controller and sequences it: it gates ball motion, requests ball re-initialisation, chooses the serve direction, and keeps score. Miss events come from game_controller, start/pause pulses come from the button debouncers, and score/state outputs go to display logic through the existing handshake path.

Parameters:
SERVE_DELAY_IN_CLOCKS, 10000, clocks between ball re-init and ball release (1 s at 10 kHz)
POINT_PAUSE_IN_CLOCKS, 20000, clocks of freeze after a point before re-init
WINNING_SCORE, 7, score that ends the match (>=1)
SCORE_WIDTH, $clog2(WINNING_SCORE+1), score counter width (derived; do not override)

Ports:
clk  input  1  slow game clock (clk_10_KHz domain)
rst  input  1  reset; asynchronous, active-low
start_req  input  1  one-cycle pulse; start or restart match
pause_req  input  1  one-cycle pulse; toggles pause during play
miss_left  input  1  one-cycle pulse; ball passed paddle 1, point to player 2
miss_right  input  1  one-cycle pulse; ball passed paddle 2, point to player 1
play_en  output  1  ball/paddle motion enable to game_controller
ball_reinit  output  1  one-cycle pulse; recentre ball at INITIAL_BALL_X/Y
serve_dir  output  1  0 = serve toward player 1 (left), 1 = toward player 2
score_1  output  SCORE_WIDTH  player 1 score
score_2  output  SCORE_WIDTH  player 2 score
game_over  output  1  match finished
winner  output  1  0 = player 1, 1 = player 2; valid only while game_over
match_state  output  3  current FSM state (match_state_t encoding)

Behaviour:
- All outputs are registered. Reset (rst low, asynchronous) forces state IDLE, play_en=0, ball_reinit=0, serve_dir=0, scores=0, game_over=0, winner=0, timer=0. Reset mid-operation aborts immediately. The first action after release is in IDLE.
- States: IDLE, SERVE, PLAY, PAUSED, POINT, OVER.
- IDLE: outputs inactive. start_req: clear scores, pulse ball_reinit next cycle, load timer with SERVE_DELAY_IN_CLOCKS-1, go to SERVE.
- SERVE: play_en=0. Timer decrements each clock. At timer==0, go to PLAY. play_en is first high exactly SERVE_DELAY_IN_CLOCKS cycles after the ball_reinit pulse.
- PLAY: play_en=1.
  - miss_left alone: score_2+1, serve_dir=0 (serve toward the conceding player).
  - miss_right alone: score_1+1, serve_dir=1.
  - Both in the same cycle: no score change, serve_dir unchanged, go to POINT.
  - After a scoring update, if the new score equals WINNING_SCORE, go to OVER. Otherwise load timer with POINT_PAUSE_IN_CLOCKS-1 and go to POINT.
  - play_en drops on the cycle after the miss.
  - Miss has priority over a simultaneous pause_req.
- PAUSED: entered from PLAY on pause_req. play_en=0, misses ignored. pause_req returns to PLAY with play_en high next cycle.
- POINT: play_en=0. Timer decrements. At timer==0, pulse ball_reinit, load SERVE delay, go to SERVE.
- OVER: play_en=0, game_over=1, winner = side that reached WINNING_SCORE. Scores hold. start_req behaves exactly as in IDLE and clears game_over/winner.
- Ignored inputs:
  - start_req in SERVE, PLAY, PAUSED, POINT.
  - miss_* outside PLAY.
  - pause_req outside PLAY/PAUSED.
- Scores saturate at WINNING_SCORE and never wrap.
- A timer load value of 0 (delay parameter 1) gives a one-cycle dwell in that state.
- ball_reinit is never high for two consecutive cycles.

Decomposition:
- game_constants_pkg:
  - match_state_t enum, 3 bits: IDLE=0, SERVE=1, PLAY=2, PAUSED=3, POINT=4, OVER=5.
  - Default constants SERVE_DELAY_IN_CLOCKS, POINT_PAUSE_IN_CLOCKS, WINNING_SCORE.
  - SERVE_DIR_LEFT/RIGHT constants.
- Sub-module match_timer: loadable down-counter with parameter WIDTH = $clog2(max(delays)).
  - Ports: clk, rst, load, load_value, en, expired.
  - Shared by SERVE and POINT.
  - Counter arithmetic lives there; the FSM stays in pong_match_sequencer.

Test Plan:
Use bench parameters SERVE_DELAY=4, POINT_PAUSE=3, WINNING_SCORE=2.
1. Reset, then start_req at cycle 0 -> ball_reinit high at cycle 1 only; match_state=SERVE; play_en rises at cycle 5; scores 0/0.
2. In PLAY, miss_right -> score_1=1, serve_dir=1, play_en low next cycle, POINT for 3 cycles, one ball_reinit pulse, SERVE 4 cycles, PLAY.
3. In PLAY, miss_left and miss_right in the same cycle -> scores unchanged, serve_dir unchanged, POINT then SERVE sequence as in 2.
4. Player 2 scores twice via miss_left -> match_state=OVER, game_over=1, winner=1, score_2=2, play_en=0; further miss_left keeps score_2=2; start_req -> scores 0/0, game_over=0, SERVE.
5. In PLAY, pause_req -> PAUSED with play_en=0; miss_left during PAUSED is ignored; second pause_req -> PLAY with play_en=1 next cycle; start_req during PLAY is ignored.
6. Assert rst low asynchronously mid-POINT (between clock edges) -> all outputs at reset values before the next clock edge; after release, miss_left has no effect and state stays IDLE until start_req.
